// File: rtl/eth_tx_frame_fifo_if.sv
// eth_tx_frame_fifo_if
// Byte-wide AXI-Stream bundle used on both sides of the frame FIFO.
// Signals:
//   tdata  - beat payload
//   tvalid - beat valid
//   tready - sink ready
//   tlast  - final beat of a frame
//   tuser  - per-beat flags; bit 0 marks a bad frame on the last beat
// Modports: master drives the beat and samples tready, slave the reverse.
interface eth_tx_frame_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_tx_frame_fifo.sv
// eth_tx_frame_fifo
// Store-and-forward frame buffer feeding the GMII transmitter. A frame becomes
// readable only once its last byte has been written, so the output never
// stalls mid-frame while the sink is ready. Bad frames (optional) and frames
// that do not fit are discarded whole. DEPTH must be a power of two >= 64;
// only DATA_WIDTH = 8 is supported.
// Ports:
//   clk, rst_n        - single clock, asynchronous active-low reset
//   s_axis (slave)    - input stream from the MAC client, never backpressured
//   m_axis (master)   - output stream to the transmitter
//   status_good_frame - pulse per committed frame
//   status_bad_frame  - pulse per frame dropped for tuser[0]
//   status_overflow   - pulse per frame dropped for lack of space
//   status_level      - bytes held (committed plus uncommitted)
module eth_tx_frame_fifo #(
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned USER_WIDTH     = 1,
    parameter bit          DROP_BAD_FRAME = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    eth_tx_frame_fifo_if.slave       s_axis,
    eth_tx_frame_fifo_if.master      m_axis,
    output logic                     status_good_frame,
    output logic                     status_bad_frame,
    output logic                     status_overflow,
    output logic [$clog2(DEPTH):0]   status_level
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PtrW   = AW + 1;
    localparam int unsigned EntryW = 1 + USER_WIDTH + DATA_WIDTH;

    typedef enum logic [0:0] {WrNormal, WrDrop} wr_state_e;

    logic [EntryW-1:0] mem [DEPTH];

    wr_state_e             wr_state_q;
    logic [PtrW-1:0]       wr_ptr_cur_q, wr_ptr_commit_q, rd_ptr_q, commit_rd_q;
    logic                  tready_q;
    logic                  good_q, bad_q, ovf_q;
    logic [PtrW-1:0]       level_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [USER_WIDTH-1:0] tuser_q;
    logic                  tlast_q, tvalid_q;

    logic            accept, full, empty, is_bad, mem_we, rd_en;
    logic [PtrW-1:0] wr_ptr_inc;

    always_comb begin
        accept     = s_axis.tvalid && tready_q;
        // Full when the pointers differ only in the wrap bit.
        full       = (wr_ptr_cur_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_cur_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        is_bad     = DROP_BAD_FRAME && s_axis.tlast && s_axis.tuser[0];
        mem_we     = accept && (wr_state_q == WrNormal) && !full && !is_bad;
        wr_ptr_inc = wr_ptr_cur_q + PtrW'(1);
        // The read side works from a one-cycle-delayed copy of the commit pointer.
        empty      = (rd_ptr_q == commit_rd_q);
        rd_en      = !empty && (!tvalid_q || m_axis.tready);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_cur_q[AW-1:0]] <= {s_axis.tlast, s_axis.tuser, s_axis.tdata};
        end
    end

    // Write FSM with pointers and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q      <= WrNormal;
            wr_ptr_cur_q    <= '0;
            wr_ptr_commit_q <= '0;
            tready_q        <= 1'b0;
            good_q          <= 1'b0;
            bad_q           <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            ovf_q    <= 1'b0;
            if (accept) begin
                unique case (wr_state_q)
                    WrNormal: begin
                        if (full) begin
                            wr_ptr_cur_q <= wr_ptr_commit_q;
                            if (s_axis.tlast) ovf_q <= 1'b1;
                            else              wr_state_q <= WrDrop;
                        end else if (is_bad) begin
                            wr_ptr_cur_q <= wr_ptr_commit_q;
                            bad_q        <= 1'b1;
                        end else begin
                            wr_ptr_cur_q <= wr_ptr_inc;
                            if (s_axis.tlast) begin
                                wr_ptr_commit_q <= wr_ptr_inc;
                                good_q          <= 1'b1;
                            end
                        end
                    end
                    WrDrop: begin
                        if (s_axis.tlast) begin
                            ovf_q      <= 1'b1;
                            wr_state_q <= WrNormal;
                        end
                    end
                    default: wr_state_q <= WrNormal;
                endcase
            end
        end
    end

    // Read side: synchronous RAM read straight into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            commit_rd_q <= '0;
            level_q     <= '0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
        end else begin
            commit_rd_q <= wr_ptr_commit_q;
            level_q     <= wr_ptr_cur_q - rd_ptr_q;
            if (rd_en) begin
                {tlast_q, tuser_q, tdata_q} <= mem[rd_ptr_q[AW-1:0]];
                tvalid_q <= 1'b1;
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end else if (m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign s_axis.tready     = tready_q;
    assign m_axis.tdata      = tdata_q;
    assign m_axis.tuser      = tuser_q;
    assign m_axis.tlast      = tlast_q;
    assign m_axis.tvalid     = tvalid_q;
    assign status_good_frame = good_q;
    assign status_bad_frame  = bad_q;
    assign status_overflow   = ovf_q;
    assign status_level      = level_q;
endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// tb_eth_tx_frame_fifo
// Scoreboard bench: every beat expected at the output is queued as it is
// driven and checked in order by a negedge monitor.
module tb_eth_tx_frame_fifo;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned UW    = 2;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_tx_frame_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(UW)) s_if ();
    eth_tx_frame_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(UW)) m_if ();

    logic          status_good_frame, status_bad_frame, status_overflow;
    logic [LW-1:0] status_level;

    eth_tx_frame_fifo #(
        .DEPTH(DEPTH), .DATA_WIDTH(8), .USER_WIDTH(UW), .DROP_BAD_FRAME(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis(s_if),
        .m_axis(m_if),
        .status_good_frame(status_good_frame),
        .status_bad_frame(status_bad_frame),
        .status_overflow(status_overflow),
        .status_level(status_level)
    );

    int total = 0;
    int bad = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_got, mon_exp;
    int beats_out = 0, good_cnt = 0, bad_cnt = 0, ovf_cnt = 0, max_level = 0;
    bit in_frame = 0;
    bit rand_ready = 0;
    bit seq_mode = 0;

    always @(posedge clk) begin
        #1;
        m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (status_good_frame) good_cnt++;
            if (status_bad_frame)  bad_cnt++;
            if (status_overflow)   ovf_cnt++;
            if (int'(status_level) > max_level) max_level = int'(status_level);
            if (in_frame) begin
                total++;
                if (!m_if.tvalid) begin
                    bad++;
                    $display("FAIL tvalid_gap: tvalid=0 required 1 inside frame at %0t", $time);
                    in_frame = 0;
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                mon_got = {m_if.tlast, m_if.tuser, m_if.tdata};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_beat: got %h required no beat at %0t", mon_got, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        bad++;
                        $display("FAIL out_beat: got %h required %h at %0t", mon_got, mon_exp,
                                 $time);
                    end
                end
                beats_out++;
                in_frame = !m_if.tlast;
            end
        end
    end

    // Called and returns at posedge+1; leaves tvalid low after the frame.
    task automatic send_frame(input int len, input bit bad_last, input bit keep);
        for (int i = 0; i < len; i++) begin
            logic [7:0]    d;
            logic [UW-1:0] u;
            logic          l;
            d = seq_mode ? 8'(i) : 8'($urandom);
            l = (i == len - 1);
            u = UW'($urandom);
            if (l) u[0] = bad_last;
            s_if.tdata  = d;
            s_if.tuser  = u;
            s_if.tlast  = l;
            s_if.tvalid = 1'b1;
            if (keep) exp_q.push_back({l, u, d});
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid || status_level != '0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s drain_timeout: pending=%0d required 0", tag, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tuser = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (s_if.tready !== 1'b0) begin
            bad++; $display("FAIL rst_tready: got %b required 0", s_if.tready);
        end
        total++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== '0) begin
            bad++; $display("FAIL rst_m_axis: got %b%b%h%h required 0", m_if.tvalid,
                            m_if.tlast, m_if.tuser, m_if.tdata);
        end
        total++;
        if ({status_good_frame, status_bad_frame, status_overflow, status_level} !== '0) begin
            bad++; $display("FAIL rst_status: got %b%b%b lvl=%0d required 0", status_good_frame,
                            status_bad_frame, status_overflow, status_level);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (s_if.tready !== 1'b1) begin
            bad++; $display("FAIL rst_release_tready: got %b required 1", s_if.tready);
        end
    endtask

    task automatic test_single_frame();
        int g0 = good_cnt, b0 = beats_out;
        seq_mode = 1;
        send_frame(60, 1'b0, 1'b1);
        seq_mode = 0;
        total++;
        if (status_good_frame !== 1'b1) begin
            bad++; $display("FAIL single_good_pulse: got %b required 1", status_good_frame);
        end
        total++;
        if (m_if.tvalid !== 1'b0) begin
            bad++; $display("FAIL single_tvalid_n1: got %b required 0", m_if.tvalid);
        end
        @(posedge clk); #1;
        total++;
        if (m_if.tvalid !== 1'b0) begin
            bad++; $display("FAIL single_tvalid_n2: got %b required 0", m_if.tvalid);
        end
        @(posedge clk); #1;
        total++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'h00) begin
            bad++; $display("FAIL single_first_beat: got v=%b d=%h required v=1 d=00",
                            m_if.tvalid, m_if.tdata);
        end
        wait_drain("single");
        total++;
        if (good_cnt - g0 != 1 || beats_out - b0 != 60) begin
            bad++; $display("FAIL single_counts: got good=%0d beats=%0d required 1 60",
                            good_cnt - g0, beats_out - b0);
        end
        total++;
        if (status_level !== '0) begin
            bad++; $display("FAIL single_level: got %0d required 0", status_level);
        end
    endtask

    task automatic test_bad_frame();
        int g0 = good_cnt, x0 = bad_cnt, b0 = beats_out;
        max_level = 0;
        send_frame(20, 1'b1, 1'b0);
        send_frame(10, 1'b0, 1'b1);
        wait_drain("bad");
        total++;
        if (bad_cnt - x0 != 1 || good_cnt - g0 != 1 || beats_out - b0 != 10) begin
            bad++; $display("FAIL bad_counts: got bad=%0d good=%0d beats=%0d required 1 1 10",
                            bad_cnt - x0, good_cnt - g0, beats_out - b0);
        end
        total++;
        if (max_level > 20) begin
            bad++; $display("FAIL bad_max_level: got %0d required <=20", max_level);
        end
    endtask

    task automatic test_overflow();
        int o0 = ovf_cnt, g0 = good_cnt, b0 = beats_out;
        send_frame(100, 1'b0, 1'b0);
        total++;
        if (status_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_pulse: got %b required 1", status_overflow);
        end
        wait_drain("ovf1");
        max_level = 0;
        send_frame(64, 1'b0, 1'b1);
        wait_drain("ovf2");
        total++;
        if (ovf_cnt - o0 != 1 || good_cnt - g0 != 1 || beats_out - b0 != 64) begin
            bad++; $display("FAIL ovf_counts: got ovf=%0d good=%0d beats=%0d required 1 1 64",
                            ovf_cnt - o0, good_cnt - g0, beats_out - b0);
        end
        total++;
        if (max_level != 64) begin
            bad++; $display("FAIL ovf_full_level: got %0d required 64", max_level);
        end
    endtask

    task automatic test_backpressure();
        int o0 = ovf_cnt, g0 = good_cnt, b0 = beats_out;
        int exp_ovf = 0, exp_beats = 0;
        rand_ready = 1;
        for (int i = 0; i < 10; i++) begin
            int len;
            len = (i % 2 == 1) ? int'($urandom_range(1, DEPTH)) : int'($urandom_range(1, 300));
            wait_drain("bp_pre");
            if (len > DEPTH) exp_ovf++;
            else exp_beats += len;
            send_frame(len, 1'b0, len <= DEPTH);
        end
        wait_drain("bp");
        rand_ready = 0;
        total++;
        if (ovf_cnt - o0 != exp_ovf || good_cnt - g0 != 10 - exp_ovf ||
            beats_out - b0 != exp_beats) begin
            bad++; $display("FAIL bp_counts: got ovf=%0d good=%0d beats=%0d required %0d %0d %0d",
                            ovf_cnt - o0, good_cnt - g0, beats_out - b0, exp_ovf,
                            10 - exp_ovf, exp_beats);
        end
    endtask

    task automatic test_back_to_back();
        int o0 = ovf_cnt, g0 = good_cnt, b0 = beats_out;
        for (int i = 0; i < 200; i++) send_frame(40, 1'b0, 1'b1);
        wait_drain("b2b");
        total++;
        if (ovf_cnt - o0 != 0 || good_cnt - g0 != 200 || beats_out - b0 != 8000) begin
            bad++; $display("FAIL b2b_counts: got ovf=%0d good=%0d beats=%0d required 0 200 8000",
                            ovf_cnt - o0, good_cnt - g0, beats_out - b0);
        end
    endtask

    task automatic test_reset_mid();
        int g0, b0, n;
        // Partial frame in flight.
        for (int i = 0; i < 15; i++) begin
            s_if.tdata = 8'($urandom); s_if.tuser = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        total++;
        if (m_if.tvalid !== 1'b0 || status_level !== '0) begin
            bad++; $display("FAIL rst_mid_write: got v=%b lvl=%0d required 0 0", m_if.tvalid,
                            status_level);
        end
        exp_q.delete(); in_frame = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        // Committed frame partly read out.
        b0 = beats_out;
        send_frame(50, 1'b0, 1'b1);
        n = 0;
        while (beats_out < b0 + 10 && n < 500) begin @(posedge clk); #1; n++; end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (m_if.tvalid !== 1'b0 || status_level !== '0 || n >= 500) begin
            bad++; $display("FAIL rst_mid_read: got v=%b lvl=%0d wait=%0d required 0 0 <500",
                            m_if.tvalid, status_level, n);
        end
        exp_q.delete(); in_frame = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        g0 = good_cnt; b0 = beats_out;
        send_frame(64, 1'b0, 1'b1);
        wait_drain("rst_after");
        total++;
        if (good_cnt - g0 != 1 || beats_out - b0 != 64) begin
            bad++; $display("FAIL rst_after_frame: got good=%0d beats=%0d required 1 64",
                            good_cnt - g0, beats_out - b0);
        end
    endtask

    initial begin
        m_if.tready = 1'b1;
        test_reset();
        test_single_frame();
        test_bad_frame();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
